// File: rtl/fp_unpack_align.sv
// FP operand unpack and exponent alignment: two-stage valid/ready pipeline feeding the adder core.
// Build option FP_UNPACK_DENORM_EN keeps denormals (eff_exp=1); otherwise zero-exponent operands flush to zero.
module fp_unpack_align #(
  parameter int C_EXP         = 5,
  parameter int C_MANT        = 10,
  parameter int C_EXP_PRENORM = 7,
  parameter int C_EXP_ZERO    = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [C_EXP+C_MANT:0]           op_a_i,
  input  logic [C_EXP+C_MANT:0]           op_b_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            sign_a_o,
  output logic                            sign_b_o,
  output logic signed [C_EXP_PRENORM-1:0] exp_o,
  output logic [C_MANT+3:0]               mant_a_o,
  output logic [C_MANT+3:0]               mant_b_o,
  output logic                            a_ge_b_o
);

  localparam int PW = C_EXP_PRENORM;
  localparam int MW = C_MANT + 4;
  localparam logic [C_EXP-1:0] EZ = C_EXP'(C_EXP_ZERO);

  function automatic logic signed [PW-1:0] eff_exp(input logic [C_EXP-1:0] e);
    logic signed [PW-1:0] r;
    if (e != EZ) begin
      r = PW'(e);
    end else begin
`ifdef FP_UNPACK_DENORM_EN
      r = PW'(1);
`else
      r = '0;
`endif
    end
    return r;
  endfunction

  function automatic logic [C_MANT-1:0] eff_mant(input logic [C_EXP-1:0] e,
                                                 input logic [C_MANT-1:0] m);
    logic [C_MANT-1:0] r;
    r = m;
`ifndef FP_UNPACK_DENORM_EN
    if (e == EZ) r = '0;
`endif
    return r;
  endfunction

  // Shift beyond the full width leaves only the sticky OR of the whole mantissa.
  function automatic logic [MW-1:0] align(input logic [MW-1:0] m, input logic [PW-1:0] d);
    logic [PW-1:0] sh;
    logic [MW-1:0] sr;
    logic [MW-1:0] mask;
    logic          lost;
    sh   = (d > PW'(MW)) ? PW'(MW) : d;
    sr   = m >> sh;
    mask = ~({MW{1'b1}} << sh);
    lost = |(m & mask);
    return {sr[MW-1:1], sr[0] | lost};
  endfunction

  logic [C_EXP-1:0]     fe_a_p0, fe_b_p0;
  logic signed [PW-1:0] ee_a_p0, ee_b_p0;
  logic                 ge_p0;

  logic                 vld_p1;
  logic                 sign_a_p1, sign_b_p1, hid_a_p1, hid_b_p1, ge_p1;
  logic [C_MANT-1:0]    mant_a_p1, mant_b_p1;
  logic signed [PW-1:0] exp_p1;
  logic [PW-1:0]        d_p1;
  logic                 s2_adv;

  assign fe_a_p0 = op_a_i[C_EXP+C_MANT-1:C_MANT];
  assign fe_b_p0 = op_b_i[C_EXP+C_MANT-1:C_MANT];
  assign ee_a_p0 = eff_exp(fe_a_p0);
  assign ee_b_p0 = eff_exp(fe_b_p0);
  assign ge_p0   = ee_a_p0 >= ee_b_p0;

  assign s2_adv  = ~valid_o | ready_i;
  assign ready_o = ~vld_p1 | s2_adv;

  // Stage 1: field split, effective exponents, exponent difference
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1    <= 1'b0;
      sign_a_p1 <= 1'b0;
      sign_b_p1 <= 1'b0;
      hid_a_p1  <= 1'b0;
      hid_b_p1  <= 1'b0;
      mant_a_p1 <= '0;
      mant_b_p1 <= '0;
      exp_p1    <= '0;
      d_p1      <= '0;
      ge_p1     <= 1'b0;
    end else if (ready_o) begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        sign_a_p1 <= op_a_i[C_EXP+C_MANT];
        sign_b_p1 <= op_b_i[C_EXP+C_MANT];
        hid_a_p1  <= fe_a_p0 != EZ;
        hid_b_p1  <= fe_b_p0 != EZ;
        mant_a_p1 <= eff_mant(fe_a_p0, op_a_i[C_MANT-1:0]);
        mant_b_p1 <= eff_mant(fe_b_p0, op_b_i[C_MANT-1:0]);
        exp_p1    <= ge_p0 ? ee_a_p0 : ee_b_p0;
        d_p1      <= ge_p0 ? PW'(ee_a_p0 - ee_b_p0) : PW'(ee_b_p0 - ee_a_p0);
        ge_p1     <= ge_p0;
      end
    end
  end

  // Stage 2: GRS extension and right-alignment of the smaller-exponent operand
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      sign_a_o <= 1'b0;
      sign_b_o <= 1'b0;
      exp_o    <= '0;
      mant_a_o <= '0;
      mant_b_o <= '0;
      a_ge_b_o <= 1'b0;
    end else if (s2_adv) begin
      valid_o <= vld_p1;
      if (vld_p1) begin
        sign_a_o <= sign_a_p1;
        sign_b_o <= sign_b_p1;
        exp_o    <= exp_p1;
        a_ge_b_o <= ge_p1;
        mant_a_o <= ge_p1 ? {hid_a_p1, mant_a_p1, 3'b000}
                          : align({hid_a_p1, mant_a_p1, 3'b000}, d_p1);
        mant_b_o <= ge_p1 ? align({hid_b_p1, mant_b_p1, 3'b000}, d_p1)
                          : {hid_b_p1, mant_b_p1, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack_align.sv
// Scoreboard bench for fp_unpack_align: stimulus pushes expected results, a monitor pops and compares.
module tb_fp_unpack_align;
  logic               clk = 1'b0;
  logic               rst_ni, valid_i, ready_o, ready_i, valid_o;
  logic               sign_a_o, sign_b_o, a_ge_b_o;
  logic [15:0]        op_a_i, op_b_i;
  logic signed [6:0]  exp_o;
  logic [13:0]        mant_a_o, mant_b_o;

  typedef struct {
    int exp; int ma; int mb; bit sa; bit sb; bit ge; int acc; bit lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mh;
  int   tests = 0, fails = 0, cyc = 0;
  bit   rdy_rand = 1'b0, rdy_val = 1'b1, lat_mode = 1'b0;

  fp_unpack_align dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .valid_o(valid_o), .ready_i(ready_i),
    .sign_a_o(sign_a_o), .sign_b_o(sign_b_o), .exp_o(exp_o),
    .mant_a_o(mant_a_o), .mant_b_o(mant_b_o), .a_ge_b_o(a_ge_b_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Value-level model: significand, effective exponent, then exact division for the shift.
  function automatic void unp(input logic [15:0] x, output int e, output int sig);
    int fe;
    fe = int'(x[14:10]);
    if (fe != 0) begin
      e = fe; sig = 1024 + int'(x[9:0]);
    end else begin
`ifdef FP_UNPACK_DENORM_EN
      e = 1; sig = int'(x[9:0]);
`else
      e = 0; sig = 0;
`endif
    end
  endfunction

  function automatic int algn(input int v, input int d);
    int p;
    if (d >= 14) return (v != 0) ? 1 : 0;
    p = 1 << d;
    return (v / p) | (((v % p) != 0) ? 1 : 0);
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int ea, eb, sa, sbg, mx;
    unp(a, ea, sa);
    unp(b, eb, sbg);
    mx = (ea >= eb) ? ea : eb;
    r.exp = mx; r.ge = (ea >= eb);
    r.ma = algn(sa * 8, mx - ea);
    r.mb = algn(sbg * 8, mx - eb);
    r.sa = a[15]; r.sb = b[15]; r.acc = 0; r.lat = 0;
    return r;
  endfunction

  function automatic exp_t mk(input int e, input int ma, input int mb, input bit ge);
    exp_t r;
    r.exp = e; r.ma = ma; r.mb = mb; r.ge = ge;
    r.sa = 0; r.sb = 0; r.acc = 0; r.lat = 0;
    return r;
  endfunction

  function automatic logic [15:0] rnd_op(input int e);
    logic [15:0] x;
    x = 16'($urandom);
    x[14:10] = 5'(e);
    return x;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e, input int gap);
    int guard;
    bit done;
    guard = 0; done = 0;
    repeat (gap) begin @(negedge clk); valid_i = 1'b0; end
    @(negedge clk);
    valid_i = 1'b1; op_a_i = a; op_b_i = b;
    while (!done) begin
      #1;
      if (ready_o) begin
        e.acc = cyc; e.lat = lat_mode;
        @(posedge clk);
        sb_q.push_back(e);
        done = 1;
      end else if (guard > 500) begin
        tests++; fails++;
        $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, required 1", guard);
        done = 1;
      end else begin
        guard++;
        @(negedge clk);
      end
    end
  endtask

  task automatic sendm(input logic [15:0] a, input logic [15:0] b, input int gap);
    send(a, b, model(a, b), gap);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d pairs outstanding, required 0", sb_q.size());
    end
  endtask

  // Monitor: checks ready_o against occupancy and compares outputs with the queue head.
  always @(negedge clk) begin
    #2;
    if (rst_ni === 1'b1) begin
      chk("ready_o", int'(ready_o), (sb_q.size() >= 2 && !ready_i) ? 0 : 1);
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_valid: valid_o=1 with nothing outstanding, required 0");
        end else begin
          mh = sb_q[0];
          chk("exp_o", int'(exp_o), mh.exp);
          chk("mant_a_o", int'(mant_a_o), mh.ma);
          chk("mant_b_o", int'(mant_b_o), mh.mb);
          chk("sign_a_o", int'(sign_a_o), int'(mh.sa));
          chk("sign_b_o", int'(sign_b_o), int'(mh.sb));
          chk("a_ge_b_o", int'(a_ge_b_o), int'(mh.ge));
          if (mh.lat && ready_i) chk("latency", cyc - mh.acc, 2);
          if (ready_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ea, eb;
    rst_ni = 1'b0; valid_i = 1'b0; op_a_i = '0; op_b_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_ready_o", int'(ready_o), 1);
    chk("rst_exp_o", int'(exp_o), 0);
    chk("rst_mant_a_o", int'(mant_a_o), 0);
    chk("rst_mant_b_o", int'(mant_b_o), 0);
    chk("rst_a_ge_b_o", int'(a_ge_b_o), 0);
    @(negedge clk);
    #3 rst_ni = 1'b1;

    // Reference vectors and alignment boundaries, ready_i held high
    lat_mode = 1'b1;
    send(16'h4000, 16'h3C00, mk(16, 'h2000, 'h1000, 1'b1), 0);
    send(16'h3C00, 16'h7800, mk(30, 'h0001, 'h2000, 1'b0), 0);
`ifdef FP_UNPACK_DENORM_EN
    send(16'h0001, 16'h0000, mk(1, 'h0008, 0, 1'b1), 0);
`else
    send(16'h0001, 16'h0000, mk(0, 0, 0, 1'b1), 0);
`endif
    send(16'h7BFF, 16'h43FF, mk(30, 'h3FF8, 'h0001, 1'b1), 0);
    sendm(16'h7BFF, 16'h47FF, 0);
    sendm(16'h4BFF, 16'hFBFF, 0);
    sendm(16'hC000, 16'h4000, 0);
    sendm(16'h7800, 16'h0000, 0);
    sendm(16'h0200, 16'h7800, 0);
    sendm(16'h0000, 16'h8000, 0);
    for (int i = 0; i < 8; i++) sendm(16'($urandom), 16'($urandom), 0);
    idle();
    drain();

    // Mid-stream stall of four cycles
    lat_mode = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) sendm(16'($urandom), 16'($urandom), 0);
      end
      begin
        repeat (3) @(posedge clk);
        rdy_val = 1'b0;
        repeat (4) @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    idle();
    drain();

    // Reset with both stages full
    rdy_val = 1'b0;
    sendm(16'h5555, 16'h2AAA, 0);
    sendm(16'h3333, 16'h4444, 0);
    @(negedge clk);
    valid_i = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", int'(valid_o), 0);
    chk("midrst_exp_o", int'(exp_o), 0);
    chk("midrst_mant_a_o", int'(mant_a_o), 0);
    chk("midrst_ready_o", int'(ready_o), 1);
    sb_q.delete();
    @(negedge clk);
    #3 rst_ni = 1'b1;
    rdy_val = 1'b1;
    lat_mode = 1'b1;
    sendm(16'h3C00, 16'h3800, 0);
    idle();
    drain();

    // Randomized traffic with random backpressure
    lat_mode = 1'b0;
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ea = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 0) begin
        eb = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
      end else begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        if (eb < 0) eb = 0;
        if (eb > 31) eb = 31;
      end
      sendm(rnd_op(ea), rnd_op(eb), int'($urandom_range(0, 2)));
    end
    idle();
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
